// File: rtl/dm_bank_pkg.sv
// dm_pkg: shared access-size encodings and clear-FSM state type for dm_bank.
package dm_pkg;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  typedef enum logic {CLEAR, READY} state_t;
endpackage

// File: rtl/dm_bank_if.sv
// dm_bank_if: MEM-stage access bus between the pipeline (master) and the data bank (slave).
interface dm_bank_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [1:0]  size;
  logic        sign_ext;
  logic        int_req;
  logic        clr;
  logic [31:0] pr_rdata;
  logic [31:0] rdata;
  logic        adel;
  logic        ades;
  logic        busy;
  modport master(output addr, wdata, mem_rd, mem_wr, size, sign_ext, int_req, clr, pr_rdata,
                 input rdata, adel, ades, busy);
  modport slave(input addr, wdata, mem_rd, mem_wr, size, sign_ext, int_req, clr, pr_rdata,
                output rdata, adel, ades, busy);
endinterface

// File: rtl/dm_bank_lane_align.sv
// dm_lane_align: byte-lane enables, store replication, load extraction/extension and misalignment check.
module dm_lane_align
  import dm_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] word,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] ld_data,
  output logic        misal
);
  logic        is_b, is_h, is_w;
  logic [31:0] shifted;
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    is_b      = size == SZ_B;
    is_h      = size == SZ_H;
    is_w      = !is_b && !is_h;
    misal     = is_h ? off[0] : is_w ? |off : 1'b0;
    be        = is_w ? 4'hf : is_h ? (off[1] ? 4'hc : 4'h3) : 4'b0001 << off;
    wdata_rep = is_w ? wdata : is_h ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
    shifted   = word >> {off, 3'b000};
    b         = shifted[7:0];
    h         = shifted[15:0];
    ld_data   = is_w ? word : is_h ? {{16{sign_ext & h[15]}}, h} : {{24{sign_ext & b[7]}}, b};
  end
endmodule

// File: rtl/dm_bank.sv
// dm_bank: MEM-stage data bank with sized loads/stores, address-error flags and a post-reset clear sweep.
module dm_bank
  import dm_pkg::*;
#(
  parameter int          ADDR_W = 12,
  parameter logic [31:0] BASE   = 32'h0000_0000
) (
  input logic       clk,
  input logic       reset,
  dm_bank_if.slave  bus
);
  logic [31:0]       mem [0:(1<<ADDR_W)-1];
  state_t            state, state_nx;
  logic [ADDR_W-1:0] ptr, ptr_nx, idx;
  logic              in_range, misal, we;
  logic [3:0]        be;
  logic [31:0]       word, wdata_rep, ld_data;
  assign idx      = bus.addr[ADDR_W+1:2];
  assign in_range = bus.addr[31:ADDR_W+2] == BASE[31:ADDR_W+2];
  assign word     = mem[idx];
  dm_lane_align u_align (
    .off(bus.addr[1:0]), .size(bus.size), .sign_ext(bus.sign_ext), .wdata(bus.wdata),
    .word(word), .be(be), .wdata_rep(wdata_rep), .ld_data(ld_data), .misal(misal)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
    end
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    if (bus.clr) begin
      state_nx = CLEAR;
      ptr_nx   = '0;
    end else if (state == CLEAR) begin
      ptr_nx   = ptr + ADDR_W'(1);
      state_nx = &ptr ? READY : CLEAR;
    end
  end
  assign we = bus.mem_wr && in_range && !misal && !bus.int_req && state == READY;
  // the array has no reset: the sweep zeroes it one word per cycle instead
  always_ff @(posedge clk)
    if (state == CLEAR) mem[ptr] <= '0;
    else if (we)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
  assign bus.rdata = !in_range ? bus.pr_rdata : state == CLEAR ? 32'h0 : ld_data;
  assign bus.adel  = bus.mem_rd & misal;
  assign bus.ades  = bus.mem_wr & misal;
  assign bus.busy  = state == CLEAR;
endmodule

// File: doc/dm_bank.md
# dm_bank

Parametrised data-memory bank for the MEM stage of the exception/interrupt pipeline. It serves byte, halfword and word loads and stores with sign or zero extension. It raises address-error exceptions for misaligned accesses and passes out-of-range accesses through to the bridge read data. After reset, and on request, a state machine clears the array one word per cycle and asserts `busy` so the pipeline stalls.

## Interface
- `ADDR_W`, 12: word-address bits; the array holds 2^ADDR_W 32-bit words.
- `BASE`, 32'h0000_0000: byte base address of the bank; aligned to 2^(ADDR_W+2).
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: reset, asynchronous and active-low.
- `addr` input 32: byte address of the access.
- `wdata` input 32: store data, right-justified (byte in [7:0], half in [15:0]).
- `mem_rd` input 1: load access this cycle.
- `mem_wr` input 1: store access this cycle.
- `size` input 2: 0 byte, 1 half, 2 word, 3 reserved (treated as word).
- `sign_ext` input 1: sign-extend byte/half loads when 1.
- `int_req` input 1: interrupt taken this cycle; suppresses the store.
- `clr` input 1: single-cycle pulse that restarts the clear sweep.
- `pr_rdata` input 32: bridge read data for out-of-range addresses.
- `rdata` output 32: load result.
- `adel` output 1: load address error.
- `ades` output 1: store address error.
- `busy` output 1: clear sweep in progress.

## Operation
- `in_range`: `addr[31:ADDR_W+2] == BASE[31:ADDR_W+2]`. Word index is `addr[ADDR_W+1:2]`.
- Misalignment:
  - half with `addr[0]`=1;
  - word/reserved with `addr[1:0]`≠0;
  - bytes never misaligned.
- Exception flags:
  - `adel` = `mem_rd` & misaligned.
  - `ades` = `mem_wr` & misaligned.
  - Both are independent of range and state.
- Byte enables:
  - word: 1111;
  - half: `addr[1]` ? 1100 : 0011;
  - byte: one-hot on `addr[1:0]`.
  - Store data is replicated into the selected lanes.
- Store commit requires all of: `mem_wr` & `in_range` & !misaligned & !`int_req` & state READY. Only the enabled lanes are written.
- Load data (`rdata`):
  - out of range: `pr_rdata` unmodified;
  - in range during CLEAR: 0;
  - otherwise: the selected lane shifted to bit 0, then sign- or zero-extended per `sign_ext`. Word loads ignore `sign_ext`.
- FSM, two states:
  - **CLEAR**: write 0 to `mem[ptr]` and increment `ptr`. Go to READY after writing the last word (`ptr` = 2^ADDR_W−1).
  - **READY**: normal access. A `clr` pulse sets `ptr`=0 and moves to CLEAR.
- `clr` during CLEAR restarts the sweep at `ptr`=0.
- `busy` = (state == CLEAR).

## Timing
- Reset assertion (asynchronous): state=CLEAR, `ptr`=0, `busy`=1 immediately. The array is not reset directly; the sweep clears it.
- Sweep length: 2^ADDR_W cycles after reset deassertion or after the `clr` edge. `busy` falls in the cycle after the last word is written.
- Reset asserted mid-sweep: the sweep restarts at `ptr`=0 after release.
- Reads are combinational: zero-latency `rdata`, `adel` and `ades`.
- Stores commit at the rising edge.
- Same-address load in the cycle of a store returns the old word. The new value is visible from the next cycle.
- Simultaneous `mem_wr` and `int_req`: nothing is written, and no other side effect occurs.
- `mem_wr` during CLEAR: dropped silently. The pipeline is required to stall on `busy`.

## Structure
- Package `dm_pkg`:
  - size encodings `SZ_B`=0, `SZ_H`=1, `SZ_W`=2;
  - FSM state typedef {CLEAR, READY}.
- Sub-module `dm_lane_align`: purely combinational. Inputs `addr[1:0]`, `size`, `sign_ext`, `wdata` and the raw word. Outputs byte enables, replicated write data, extracted load data and the misaligned flag.
- Top module: array, clear FSM and pointer, range decode, output muxing.

## Test plan
- Release reset with `ADDR_W`=12 → `busy`=1 for exactly 4096 cycles, then 0. Any word loaded afterwards reads 0x00000000.
- sw 0x12345678 @0x10, then:
  - lb signed @0x11 → 0x00000056;
  - lhu @0x12 → 0x00001234;
  - lw @0x10 → 0x12345678.
- sb 0x80 @0x13, then:
  - lb signed @0x13 → 0xFFFFFF80;
  - lbu @0x13 → 0x00000080;
  - lw @0x10 → 0x80345678.
- Misaligned accesses:
  - sw @0x12 → `ades`=1 and the word at 0x10 is unchanged;
  - lh @0x11 → `adel`=1.
- Store suppression and range:
  - sw 0xDEADBEEF @0x20 with `int_req`=1 → lw @0x20 returns 0;
  - load @0x7F00 with `pr_rdata`=0xCAFEF00D → `rdata`=0xCAFEF00D and no exception.
- Pulse `clr` after writes, then assert reset when `ptr`=100 → `busy` stays high. After release, the sweep restarts from 0, completes in 4096 cycles, and all words read 0.
